// File: rtl/wb_regfile.sv
// Writeback mux, 32x32 architectural register file and retired-write counter.
// Optional macro WB_BYPASS_EN forwards the committing value to the read ports in the same cycle.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_memdata,
  input  logic [31:0] wb_aludata,
  input  logic [4:0]  wb_rd,
  input  logic        wb_mem2reg,
  input  logic        wb_regwr,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] wb_wdata,
  output logic        wb_commit,
  output logic [31:0] wb_count
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] count_q;
  logic [31:0] count_d;

  assign wb_wdata  = wb_mem2reg ? wb_memdata : wb_aludata;
  assign wb_commit = wb_regwr && (wb_rd != 5'd0);
  assign wb_count  = count_q;

  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (wb_commit) begin
      regs_d[wb_rd] = wb_wdata;
      count_d       = count_q + 32'd1;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q  <= '{default: '0};
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  // Index 0 is decoded explicitly so $0 reads zero even before the first reset.
  always_comb begin
    rdata1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
    rdata2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];
`ifdef WB_BYPASS_EN
    if (wb_commit && (ra1 == wb_rd)) rdata1 = wb_wdata;
    if (wb_commit && (ra2 == wb_rd)) rdata2 = wb_wdata;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases plus random traffic against an array model.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] wb_memdata;
  logic [31:0] wb_aludata;
  logic [4:0]  wb_rd;
  logic        wb_mem2reg;
  logic        wb_regwr;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] wb_wdata;
  logic        wb_commit;
  logic [31:0] wb_count;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .wb_memdata (wb_memdata),
    .wb_aludata (wb_aludata),
    .wb_rd      (wb_rd),
    .wb_mem2reg (wb_mem2reg),
    .wb_regwr   (wb_regwr),
    .ra1        (ra1),
    .ra2        (ra2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .wb_wdata   (wb_wdata),
    .wb_commit  (wb_commit),
    .wb_count   (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_wdata();
    return wb_mem2reg ? wb_memdata : wb_aludata;
  endfunction

  function automatic logic m_commit();
    return wb_regwr && (wb_rd != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (m_commit() && ra == wb_rd) return m_wdata();
`endif
    return m_regs[ra];
  endfunction

  // Inputs are driven just after a falling edge; outputs checked 1 time unit later,
  // then the model advances with the rising edge.
  task automatic step(input logic r, input logic [31:0] md, input logic [31:0] ad,
                      input logic [4:0] rd, input logic m2r, input logic we,
                      input logic [4:0] a1, input logic [4:0] a2);
    rst = r; wb_memdata = md; wb_aludata = ad; wb_rd = rd;
    wb_mem2reg = m2r; wb_regwr = we; ra1 = a1; ra2 = a2;
    #1;
    chk("wb_wdata",  wb_wdata,  m_wdata());
    chk("wb_commit", {31'd0, wb_commit}, {31'd0, m_commit()});
    chk("rdata1",    rdata1,    m_read(ra1));
    chk("rdata2",    rdata2,    m_read(ra2));
    chk("wb_count",  wb_count,  m_count);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count = 32'd0;
    end else if (m_commit()) begin
      m_regs[wb_rd] = m_wdata();
      m_count = m_count + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic rd_only(input logic [4:0] a1, input logic [4:0] a2);
    step(1'b0, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0, a1, a2);
  endtask

  initial begin
    logic [4:0] rd, a1, a2;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_count = 32'd0;
    rst = 1'b1; wb_memdata = '0; wb_aludata = '0; wb_rd = '0;
    wb_mem2reg = 1'b0; wb_regwr = 1'b0; ra1 = '0; ra2 = '0;
    @(posedge clk);
    @(negedge clk);

    // fill 1..31, then hold reset two cycles with writes still presented
    for (int i = 1; i < 32; i++)
      step(1'b0, $urandom, $urandom | 32'h1, 5'(i), 1'b0, 1'b1, 5'(i - 1), 5'(i));
    chk("count_after_fill", wb_count, 32'd31);
    step(1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd9, 1'b1, 1'b1, 5'd9, 5'd31);
    step(1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd9, 1'b0, 1'b1, 5'd9, 5'd31);
    for (int i = 0; i < 32; i++) rd_only(5'(i), 5'(31 - i));
    chk("count_after_rst", wb_count, 32'd0);

    // basic ALU and load writeback
    step(1'b0, 32'h0, 32'h12345678, 5'd5, 1'b0, 1'b1, 5'd1, 5'd2);
    step(1'b0, 32'hDEADBEEF, 32'h0, 5'd6, 1'b1, 1'b1, 5'd5, 5'd0);
    chk("basic_alu_r5", rdata1, 32'h12345678);
    rd_only(5'd5, 5'd6);
    chk("basic_mem_r6", rdata2, 32'hDEADBEEF);
    chk("basic_count", wb_count, 32'd2);

    // writes to $0 are discarded and uncounted
    step(1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0);
    rd_only(5'd0, 5'd5);
    chk("r0_zero", rdata1, 32'd0);
    chk("r0_count", wb_count, 32'd2);

    // bypass scenario on r7
    step(1'b0, 32'h0, 32'h1, 5'd7, 1'b0, 1'b1, 5'd7, 5'd7);
    step(1'b0, 32'h0, 32'hAA, 5'd7, 1'b0, 1'b1, 5'd7, 5'd7);
    rd_only(5'd7, 5'd7);
    chk("bypass_after", rdata1, 32'hAA);

    // reset and write on the same edge: reset wins
    step(1'b1, 32'h0, 32'h55, 5'd3, 1'b0, 1'b1, 5'd3, 5'd3);
    rd_only(5'd3, 5'd7);
    chk("collide_r3", rdata1, 32'd0);
    chk("collide_count", wb_count, 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      step(($urandom_range(0, 39) == 0), $urandom, $urandom, rd,
           1'($urandom), 1'($urandom), a1, a2);
    end
    rd_only(5'd1, 5'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the pipelined MIPS core. Consumes the MEM/WB pipeline register outputs, selects the writeback value (load data or ALU result), and commits it to a 32×32-bit register file. Serves the two combinational read ports used by the ID stage, with optional same-cycle write-to-read bypass, and counts retired register writes for debug.

## Interface
Parameters:
- none; geometry fixed at 32 registers × 32 bits.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_memdata  in  32  load data from MEM/WB
- wb_aludata  in  32  ALU result from MEM/WB
- wb_rd  in  5  destination register index
- wb_mem2reg  in  1  1 selects wb_memdata, 0 selects wb_aludata
- wb_regwr  in  1  register write enable
- ra1  in  5  read address, port 1 (rs)
- ra2  in  5  read address, port 2 (rt)
- rdata1  out  32  read data, port 1
- rdata2  out  32  read data, port 2
- wb_wdata  out  32  selected writeback value, for EX-stage forwarding
- wb_commit  out  1  wb_regwr && wb_rd != 0, combinational
- wb_count  out  32  number of committed writes since reset

## Operation
- Writeback mux: wb_wdata = wb_mem2reg ? wb_memdata : wb_aludata; purely combinational.
- Commit: on rising clk with rst=0 and wb_commit=1, regs[wb_rd] <= wb_wdata.
- Register 0: hardwired zero; writes to index 0 discarded, never counted; reads of index 0 return 0 in all cases, including under bypass.
- Reads: asynchronous; rdataN = regs[raN] (subject to bypass, see Configuration).
- Both read ports may address the same register, and may equal wb_rd; each port resolved independently.
- wb_count: +1 on every rising edge where wb_commit=1 and rst=0; wraps 0xFFFFFFFF -> 0.
- Reset: on rising clk with rst=1, all 32 registers and wb_count cleared to 0; a write presented in the same cycle is dropped and not counted (rst has priority).
- Undefined/X on wb_regwr is not permitted; wb_rd, data may be X when wb_regwr=0.

## Timing
- Write latency: value visible in regs one edge after presentation; visible on rdataN in the cycle after the edge without bypass, in the same cycle with bypass.
- Reset values: rdata1=rdata2=0 and wb_count=0 from the first edge with rst=1 onward; wb_wdata and wb_commit follow inputs combinationally regardless of rst.
- Reset mid-operation: registers cleared at that edge; writes resume on the first edge with rst=0.
- No handshake; one commit per cycle max, no backpressure.
- Combinational paths: wb_* -> wb_wdata/wb_commit; ra* -> rdata*; with bypass also wb_* -> rdata*.

## Configuration
- Macro WB_BYPASS_EN.
- Defined: if wb_commit=1 and raN == wb_rd, rdataN = wb_wdata in the same cycle (write-before-read); ID stage needs no extra stall for WB->ID hazards.
- Not defined: rdataN always returns stored regs[raN]; hazard unit must stall ID one cycle for a WB->ID dependency. wb_wdata/wb_count behaviour unchanged.

## Test plan
- Reset: hold rst=1 two cycles after writing regs 1..31 -> all reads 0, wb_count=0.
- Basic write/read: wb_rd=5, wb_mem2reg=0, wb_aludata=0x12345678, wb_regwr=1, one edge -> ra1=5 gives 0x12345678, wb_count=1; repeat with wb_mem2reg=1, wb_memdata=0xDEADBEEF on rd=6 -> ra2=6 gives 0xDEADBEEF.
- $0 protection: write 0xFFFFFFFF to rd=0 -> rdata1(ra1=0)=0, wb_commit=0, wb_count unchanged.
- Bypass: regs[7]=0x1, present write 0xAA to rd=7 with ra1=ra2=7 -> with WB_BYPASS_EN both read 0xAA before the edge; without, both read 0x1 before and 0xAA after.
- Reset vs write collision: rst=1 and write 0x55 to rd=3 same edge -> regs[3]=0, wb_count=0.
- Counter wrap: force 2^32 commits (or preload via long run in fast sim) -> wb_count wraps to 0 on the next commit.
